// File: rtl/mux_sel2_if.sv
// Operand/select/result bundle for the registered 2:1 selector.
// The master drives a, b, s and en; the slave returns out and sel_q.
interface mux_sel2_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             sel_q;

  modport master (
    output a,
    output b,
    output s,
    output en,
    input  out,
    input  sel_q
  );

  modport slave (
    input  a,
    input  b,
    input  s,
    input  en,
    output out,
    output sel_q
  );
endinterface

// File: rtl/mux_sel2.sv
// Registered 2:1 selector: out takes b when s=1, otherwise a, one clk after sampling.
// sel_q records which operand produced the value currently on out.
module mux_sel2 #(
  parameter int          WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  mux_sel2_if.slave   bus
);

  localparam logic [WIDTH-1:0] RST_VALUE = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             sel_state_q;
  logic             sel_state_d;

  // a ^ ((a ^ b) & s): lanes where a==b never depend on s, so an unknown
  // select cannot smear X onto bits that agree on both operands.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign pick[gi] = bus.a[gi] ^ ((bus.a[gi] ^ bus.b[gi]) & bus.s);
    end
  endgenerate

  always_comb begin
    out_d       = out_q;
    sel_state_d = sel_state_q;
    if (bus.en) begin
      out_d       = pick;
      sel_state_d = bus.s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= RST_VALUE;
      sel_state_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      sel_state_q <= sel_state_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.sel_q = sel_state_q;

endmodule

// File: tb/tb_mux_sel2.sv
// Bench for mux_sel2: a 1-bit and an 8-bit (RESET_VAL=A5) instance, directed
// steps from the plan followed by random traffic checked against a reference model.
module tb_mux_sel2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst8;

  mux_sel2_if #(.WIDTH(1)) b1 ();
  mux_sel2_if #(.WIDTH(8)) b8 ();

  mux_sel2 #(.WIDTH(1), .RESET_VAL(64'd0)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  mux_sel2 #(.WIDTH(8), .RESET_VAL(64'hA5)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: what each output should hold after the edge.
  logic       m1_out;
  logic       m1_sel;
  logic [7:0] m8_out;
  logic       m8_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Apply the rule to the inputs presented at this edge, let the edge happen,
  // then compare both instances against the model 1 time unit later.
  task automatic tick();
    if (rst1) begin
      m1_out = 1'b0;
      m1_sel = 1'b0;
    end else if (b1.en) begin
      m1_out = (b1.s == 1'b1) ? b1.b : b1.a;
      m1_sel = b1.s;
    end
    if (rst8) begin
      m8_out = 8'hA5;
      m8_sel = 1'b0;
    end else if (b8.en) begin
      m8_out = (b8.s == 1'b1) ? b8.b : b8.a;
      m8_sel = b8.s;
    end
    @(posedge clk);
    #1;
    $display("t=%0t w1 rst=%0b a=%0b b=%0b s=%0b en=%0b -> out=%0b sel=%0b | w8 rst=%0b a=%02h b=%02h s=%0b en=%0b -> out=%02h sel=%0b",
             $time, rst1, b1.a, b1.b, b1.s, b1.en, b1.out, b1.sel_q,
             rst8, b8.a, b8.b, b8.s, b8.en, b8.out, b8.sel_q);
    chk("w1_out_model", 64'(b1.out), 64'(m1_out));
    chk("w1_sel_model", 64'(b1.sel_q), 64'(m1_sel));
    chk("w8_out_model", 64'(b8.out), 64'(m8_out));
    chk("w8_sel_model", 64'(b8.sel_q), 64'(m8_sel));
  endtask

  initial begin
    logic [7:0] truth;
    logic [2:0] abs;
    truth = 8'b1101_1000;

    // Reset held for two edges with every input pulling towards 1.
    rst1 = 1'b1; rst8 = 1'b1;
    b1.a = 1'b1; b1.b = 1'b1; b1.s = 1'b1; b1.en = 1'b1;
    b8.a = 8'hFF; b8.b = 8'hFF; b8.s = 1'b1; b8.en = 1'b1;
    tick();
    tick();
    chk("reset_w1_out", 64'(b1.out), 64'd0);
    chk("reset_w1_sel", 64'(b1.sel_q), 64'd0);
    chk("reset_w8_out", 64'(b8.out), 64'hA5);
    chk("reset_w8_sel", 64'(b8.sel_q), 64'd0);

    rst1 = 1'b0; rst8 = 1'b0;
    tick();
    chk("release_w1_out", 64'(b1.out), 64'd1);
    chk("release_w8_out", 64'(b8.out), 64'hFF);

    // Truth-table sweep with a one-edge reset injected after entry 3.
    for (int i = 0; i < 8; i++) begin
      abs = 3'(i);
      b1.a = abs[2]; b1.b = abs[1]; b1.s = abs[0]; b1.en = 1'b1;
      tick();
      chk($sformatf("sweep_out_%0d", i), 64'(b1.out), 64'(truth[i]));
      chk($sformatf("sweep_sel_%0d", i), 64'(b1.sel_q), 64'(abs[0]));
      if (i == 3) begin
        rst1 = 1'b1; b1.a = 1'b1; b1.s = 1'b0;
        tick();
        chk("midrst_out", 64'(b1.out), 64'd0);
        rst1 = 1'b0;
        tick();
        chk("midrst_release_out", 64'(b1.out), 64'd1);
      end
    end

    // Enable hold.
    b1.a = 1'b1; b1.s = 1'b0; b1.en = 1'b1;
    tick();
    chk("hold_prime_out", 64'(b1.out), 64'd1);
    b1.en = 1'b0; b1.s = 1'b1; b1.b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_out_%0d", i), 64'(b1.out), 64'd1);
      chk($sformatf("hold_sel_%0d", i), 64'(b1.sel_q), 64'd0);
    end
    b1.en = 1'b1;
    tick();
    chk("hold_release_out", 64'(b1.out), 64'd0);
    chk("hold_release_sel", 64'(b1.sel_q), 64'd1);

    // Wide datapath: reset value, then alternating select.
    rst8 = 1'b1; b8.en = 1'b1;
    tick();
    chk("wide_reset_out", 64'(b8.out), 64'hA5);
    rst8 = 1'b0; b8.a = 8'h3C; b8.b = 8'hC3;
    for (int k = 0; k < 6; k++) begin
      b8.s = k[0];
      tick();
      chk($sformatf("wide_alt_%0d", k), 64'(b8.out), k[0] ? 64'hC3 : 64'h3C);
    end

    // Select and selected operand change on the same edge.
    b8.s = 1'b0; b8.b = 8'h00;
    tick();
    chk("collide_pre_out", 64'(b8.out), 64'h3C);
    b8.s = 1'b1; b8.b = 8'hFF;
    tick();
    chk("collide_out", 64'(b8.out), 64'hFF);
    chk("collide_sel", 64'(b8.sel_q), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      rst1  = ($urandom_range(0, 15) == 0);
      rst8  = ($urandom_range(0, 15) == 0);
      b1.a  = 1'($urandom_range(0, 1));
      b1.b  = 1'($urandom_range(0, 1));
      b1.s  = 1'($urandom_range(0, 1));
      b1.en = ($urandom_range(0, 3) != 0);
      b8.a  = 8'($urandom);
      b8.b  = 8'($urandom);
      b8.s  = 1'($urandom_range(0, 1));
      b8.en = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
